io_bus_bridge: RTL and testbench
================================

IO_BUS_BRIDGE -- requirements
Module: io_bus_bridge

Interface
REQ-001 Parameters SHALL be:
- NSLV, 8: number of peripheral channels.
- DW, 16: slave data width, 8..16.
- WS0, 7: wait states at speed 0 (slow).
- WS1, 5: wait states at speed 1 (medium).
- WS2, 3: wait states at speed 2 (fast).
- WS3, 1: wait states at speed 3 (sync).
- TIMEOUT, 64: maximum STROBE cycles before error.
REQ-002 The block SHALL have one clock, clkcpu; reset rst_n is asynchronous and active-low.
REQ-003 Ports SHALL be:
- clkcpu  in  1  system clock.
- rst_n  in  1  async active-low reset.
- wb_cyc  in  1  CPU cycle.
- wb_stb  in  1  CPU strobe.
- wb_we  in  1  write enable.
- wb_dat_i  in  32  CPU write data.
- sel_i  in  NSLV  channel selects from address decode.
- speed_i  in  2  IOC cycle speed.
- wb_dat_o  out  32  read data.
- wb_ack  out  1  access complete.
- wb_err  out  1  access timed out.
- s_stb  out  NSLV  per-channel strobe.
- s_we  out  1  latched write enable.
- s_dat_o  out  DW  latched write data.
- s_ack_i  in  NSLV  per-channel acknowledge.
- s_dat_i  in  NSLV*DW  channel k read data on bits [k*DW+DW-1:k*DW].

Function
REQ-004 The FSM SHALL have four states: IDLE, WAIT, STROBE, DONE.
REQ-005 In IDLE, when wb_cyc&wb_stb=1 at a rising edge, the block SHALL latch the following and enter WAIT:
- channel = lowest-index set bit of sel_i, or NONE if sel_i=0.
- speed_i.
- wb_we.
- wb_dat_i[DW+15:16] into s_dat_o.
REQ-006 WAIT SHALL last exactly WSn+1 cycles, where n is the latched speed, using a down-counter sized to the largest WSn.
REQ-007 WAIT exit SHALL go to STROBE if a channel is latched, or to DONE with data 32'hFFFF_FFFF if the channel is NONE.
REQ-008 In STROBE, s_stb[channel] SHALL be 1 and every other s_stb bit 0.
REQ-009 In STROBE, when s_ack_i[channel]=1 the block SHALL capture the zero-extended channel data into wb_dat_o (reads only) and enter DONE on the next edge.
REQ-010 s_ack_i bits of non-selected channels SHALL be ignored.
REQ-011 If s_ack_i[channel] stays 0 for TIMEOUT consecutive STROBE cycles, the block SHALL enter DONE with wb_err=1 in place of wb_ack and wb_dat_o=32'hFFFF_FFFF.
REQ-012 DONE SHALL last one cycle with exactly one of wb_ack or wb_err high, then return to IDLE.
REQ-013 A new request SHALL be accepted no earlier than the first IDLE cycle after DONE, giving one idle cycle between back-to-back accesses.
REQ-014 Latency: request sampled at edge 0 with a slave that acks in its first STROBE cycle SHALL produce wb_ack in cycle WSn+3.
REQ-015 If wb_cyc falls in WAIT or STROBE, the block SHALL return to IDLE on the next edge:
- s_stb cleared.
- no ack or err issued.
- wb_dat_o unchanged.
REQ-016 sel_i and speed_i changes after latching SHALL have no effect on the access in progress.
REQ-017 Writes SHALL follow the same sequence; wb_dat_o SHALL be unchanged by a write.
REQ-018 s_we SHALL equal the latched wb_we while in STROBE and be 0 otherwise.

Reset
REQ-019 While rst_n=0 the block SHALL hold:
- state IDLE.
- wb_ack=0, wb_err=0.
- s_stb=0, s_we=0.
- s_dat_o=0.
- wb_dat_o=32'hFFFF_FFFF.
- all counters 0.
REQ-020 Reset asserted mid-access SHALL abort the access immediately, with no ack or err after release.
REQ-021 The first request SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-022 Read, speed_i=3, sel_i=8'h02, slave 1 acks at once with 16'h00A5 -> s_stb=8'h02 in cycle 3 only; wb_ack in cycle 4; wb_dat_o=32'h0000_00A5.
REQ-023 Write, speed_i=0, sel_i=8'h10, wb_dat_i=32'h1234_0000 -> s_stb[4]=1 and s_we=1 from cycle 9; s_dat_o=16'h1234; wb_ack one cycle after the slave ack.
REQ-024 sel_i=8'h00, speed_i=2 -> no s_stb; wb_ack in cycle 5; wb_dat_o=32'hFFFF_FFFF.
REQ-025 sel_i=8'h0C, slave never acks -> only s_stb[2] high, for exactly 64 cycles; then wb_err=1 for one cycle; wb_ack stays 0; wb_dat_o=32'hFFFF_FFFF.
REQ-026 wb_cyc dropped in the second WAIT cycle, then rst_n pulsed low during a later STROBE -> both accesses abort: no ack, no err, s_stb=0, FSM in IDLE.

Source files
------------

// File: rtl/io_bus_bridge_if.sv
// io_bus_bridge_if -- CPU-side and peripheral-side bus bundle for io_bus_bridge.
//
// Signals
//   wb_cyc, wb_stb, wb_we, wb_dat_i   CPU request (cycle, strobe, write enable, write data)
//   sel_i                             per-channel select from the CPU address decode
//   speed_i                           access speed class (0 slow .. 3 sync)
//   wb_dat_o, wb_ack, wb_err          CPU response (read data, completion, timeout)
//   s_stb, s_we, s_dat_o              peripheral strobe, write enable and write data
//   s_ack_i, s_dat_i                  peripheral acknowledge and packed read data
//
// Modports
//   master : the environment (CPU plus peripherals) driving requests and slave replies
//   slave  : the bridge itself
interface io_bus_bridge_if #(
   parameter int NSLV = 8,
   parameter int DW   = 16
);
   logic                 wb_cyc;
   logic                 wb_stb;
   logic                 wb_we;
   logic [31:0]          wb_dat_i;
   logic [NSLV-1:0]      sel_i;
   logic [1:0]           speed_i;
   logic [31:0]          wb_dat_o;
   logic                 wb_ack;
   logic                 wb_err;
   logic [NSLV-1:0]      s_stb;
   logic                 s_we;
   logic [DW-1:0]        s_dat_o;
   logic [NSLV-1:0]      s_ack_i;
   logic [NSLV*DW-1:0]   s_dat_i;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_dat_i, sel_i, speed_i, s_ack_i, s_dat_i,
      input  wb_dat_o, wb_ack, wb_err, s_stb, s_we, s_dat_o
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_dat_i, sel_i, speed_i, s_ack_i, s_dat_i,
      output wb_dat_o, wb_ack, wb_err, s_stb, s_we, s_dat_o
   );
endinterface

// File: rtl/io_bus_bridge.sv
// io_bus_bridge -- bridges single CPU bus accesses onto one of NSLV slow
// peripheral channels, inserting a speed-dependent number of wait states
// before strobing the channel and timing out channels that never acknowledge.
//
// Ports
//   clkcpu   system clock
//   rst_n    asynchronous active-low reset
//   bus      io_bus_bridge_if.slave: CPU request/response and per-channel
//            strobe/acknowledge/data (see the interface file for the list)
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for wb_cyc & wb_stb; request is latched on acceptance
//   ST_WAIT   | counting down WSn+1 wait-state cycles for the latched speed
//   ST_STROBE | s_stb asserted on the latched channel, waiting for its ack
//   ST_DONE   | one-cycle wb_ack or wb_err pulse, then back to ST_IDLE
module io_bus_bridge #(
   parameter int NSLV    = 8,
   parameter int DW      = 16,
   parameter int WS0     = 7,
   parameter int WS1     = 5,
   parameter int WS2     = 3,
   parameter int WS3     = 1,
   parameter int TIMEOUT = 64
) (
   input logic           clkcpu,
   input logic           rst_n,
   io_bus_bridge_if.slave bus
);

   localparam int CHW    = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int WS_01  = (WS0 > WS1) ? WS0 : WS1;
   localparam int WS_23  = (WS2 > WS3) ? WS2 : WS3;
   localparam int WS_MAX = (WS_01 > WS_23) ? WS_01 : WS_23;
   localparam int WCW    = (WS_MAX > 0) ? $clog2(WS_MAX + 1) : 1;
   localparam int TCW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_STROBE,
      ST_DONE
   } state_t;

   state_t            state;
   logic [CHW-1:0]    chan;
   logic              chan_vld;
   logic              we_q;
   logic [WCW-1:0]    wait_cnt;
   logic [TCW-1:0]    to_cnt;
   logic              ack_q;
   logic              err_q;
   logic [NSLV-1:0]   stb_q;
   logic              s_we_q;
   logic [DW-1:0]     s_dat_q;
   logic [31:0]       rd_q;

   logic [WCW-1:0]    ws_load;
   logic [CHW-1:0]    req_chan;
   logic [DW-1:0]     chan_dat;
   logic              chan_ack;
   logic [NSLV-1:0]   chan_onehot;

   // Lowest-index set bit wins when the address decode selects several channels.
   function automatic logic [CHW-1:0] lowest_set(input logic [NSLV-1:0] v);
      logic [CHW-1:0] idx;
      idx = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if (v[i]) idx = CHW'(i);
      end
      return idx;
   endfunction

   // The wait counter is loaded with WSn, so WAIT spans WSn+1 cycles
   // (the cycle that sees zero is the last WAIT cycle).
   always_comb begin
      ws_load = '0;
      case (bus.speed_i)
         2'd0:    ws_load = WCW'(WS0);
         2'd1:    ws_load = WCW'(WS1);
         2'd2:    ws_load = WCW'(WS2);
         default: ws_load = WCW'(WS3);
      endcase
   end

   assign req_chan = lowest_set(bus.sel_i);

   // Only the latched channel's ack and data are looked at; other channels'
   // acks are ignored entirely.
   always_comb begin
      chan_dat    = '0;
      chan_ack    = 1'b0;
      chan_onehot = '0;
      for (int k = 0; k < NSLV; k++) begin
         if (chan == CHW'(k)) begin
            chan_dat       = bus.s_dat_i[k*DW +: DW];
            chan_ack       = bus.s_ack_i[k];
            chan_onehot[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         chan     <= '0;
         chan_vld <= 1'b0;
         we_q     <= 1'b0;
         wait_cnt <= '0;
         to_cnt   <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         stb_q    <= '0;
         s_we_q   <= 1'b0;
         s_dat_q  <= '0;
         rd_q     <= 32'hFFFF_FFFF;
      end else begin
         // Response pulses are single-cycle; they are only raised on entry to DONE.
         ack_q <= 1'b0;
         err_q <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (bus.wb_cyc && bus.wb_stb) begin
                  chan     <= req_chan;
                  chan_vld <= |bus.sel_i;
                  we_q     <= bus.wb_we;
                  s_dat_q  <= bus.wb_dat_i[DW+15:16];
                  wait_cnt <= ws_load;
                  state    <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (!bus.wb_cyc) begin
                  wait_cnt <= '0;
                  state    <= ST_IDLE;
               end else if (wait_cnt == '0) begin
                  if (chan_vld) begin
                     stb_q  <= chan_onehot;
                     s_we_q <= we_q;
                     to_cnt <= TCW'(TIMEOUT - 1);
                     state  <= ST_STROBE;
                  end else begin
                     // No channel decoded: complete immediately with all-ones read data.
                     ack_q <= 1'b1;
                     if (!we_q) rd_q <= 32'hFFFF_FFFF;
                     state <= ST_DONE;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end

            ST_STROBE: begin
               // A dropped cycle takes priority over an ack arriving in the same cycle.
               if (!bus.wb_cyc) begin
                  stb_q  <= '0;
                  s_we_q <= 1'b0;
                  to_cnt <= '0;
                  state  <= ST_IDLE;
               end else if (chan_ack) begin
                  stb_q  <= '0;
                  s_we_q <= 1'b0;
                  to_cnt <= '0;
                  ack_q  <= 1'b1;
                  if (!we_q) rd_q <= {{(32-DW){1'b0}}, chan_dat};
                  state  <= ST_DONE;
               end else if (to_cnt == '0) begin
                  // Last of TIMEOUT strobe cycles without an ack.
                  stb_q  <= '0;
                  s_we_q <= 1'b0;
                  err_q  <= 1'b1;
                  if (!we_q) rd_q <= 32'hFFFF_FFFF;
                  state  <= ST_DONE;
               end else begin
                  to_cnt <= to_cnt - 1'b1;
               end
            end

            ST_DONE: begin
               // Requests seen here are not accepted; the CPU gets one idle cycle.
               state <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.wb_dat_o = rd_q;
   assign bus.wb_ack   = ack_q;
   assign bus.wb_err   = err_q;
   assign bus.s_stb    = stb_q;
   assign bus.s_we     = s_we_q;
   assign bus.s_dat_o  = s_dat_q;

endmodule

// File: tb/tb_io_bus_bridge.sv
module tb_io_bus_bridge;
   localparam int NSLV    = 8;
   localparam int DW      = 16;
   localparam int TIMEOUT = 64;

   logic clkcpu = 1'b0;
   logic rst_n  = 1'b0;

   io_bus_bridge_if #(.NSLV(NSLV), .DW(DW)) bus ();

   io_bus_bridge #(
      .NSLV(NSLV), .DW(DW), .WS0(7), .WS1(5), .WS2(3), .WS3(1), .TIMEOUT(TIMEOUT)
   ) dut (
      .clkcpu(clkcpu),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clkcpu = ~clkcpu;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0]   exp_dat  = 32'hFFFF_FFFF;
   logic [DW-1:0] exp_sdat = '0;

   function automatic int ws_of(input logic [1:0] spd);
      case (spd)
         2'd0:    return 7;
         2'd1:    return 5;
         2'd2:    return 3;
         default: return 1;
      endcase
   endfunction

   function automatic logic [NSLV*DW-1:0] rand_sd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkcpu);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " stb"}, 32'(bus.s_stb), 32'h0);
      chk({tag, " we"},  32'(bus.s_we),  32'h0);
      chk({tag, " ack"}, 32'(bus.wb_ack), 32'h0);
      chk({tag, " err"}, 32'(bus.wb_err), 32'h0);
      chk({tag, " dat"}, bus.wb_dat_o, exp_dat);
   endtask

   // kind: 0 = complete normally, 1 = drop wb_cyc in cycle 'at', 2 = reset pulse in cycle 'at'.
   // dly: slave ack arrives dly cycles into STROBE; dly >= TIMEOUT means never.
   // Cycle c counts from 1 = first cycle after the accepting edge.
   task automatic run_txn(input string name, input logic [NSLV-1:0] sel, input logic [1:0] spd,
                          input logic we, input logic [31:0] wdat, input int dly,
                          input logic [NSLV*DW-1:0] sd, input int kind, input int at_in);
      int ws, ch, sstart, slen, done_c, at;
      logic [NSLV-1:0] oh;
      logic in_strobe, timed_out;
      ws = ws_of(spd);
      ch = -1;
      for (int i = NSLV - 1; i >= 0; i--) if (sel[i]) ch = i;
      oh = '0;
      if (ch >= 0) oh[ch] = 1'b1;
      timed_out = (ch >= 0) && (dly >= TIMEOUT);
      sstart = ws + 2;
      if (ch < 0)            begin slen = 0;       done_c = ws + 2; end
      else if (!timed_out)   begin slen = dly + 1; done_c = sstart + slen; end
      else                   begin slen = TIMEOUT; done_c = sstart + TIMEOUT; end
      at = at_in;
      if (kind != 0 && at < 1) at = 1 + int'($urandom % 32'(done_c - 1));

      bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = we; bus.wb_dat_i = wdat;
      bus.sel_i = sel; bus.speed_i = spd; bus.s_dat_i = sd; bus.s_ack_i = '0;
      tick();
      exp_sdat = wdat[DW+15:16];

      for (int c = 1; c <= done_c; c++) begin
         if (kind == 2 && c == at) begin
            #2 rst_n = 1'b0;
            #1;
            exp_dat  = 32'hFFFF_FFFF;
            exp_sdat = '0;
            chk_idle({name, " rst"});
            chk({name, " rst sdat"}, 32'(bus.s_dat_o), 32'h0);
            bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.s_ack_i = '0;
            @(negedge clkcpu) rst_n = 1'b1;
            for (int j = 0; j < 3; j++) begin
               tick();
               chk_idle({name, " post-rst"});
            end
            return;
         end
         if (kind == 1 && c == at + 1) begin
            chk_idle({name, " abort"});
            return;
         end
         in_strobe = (ch >= 0) && (c >= sstart) && (c < sstart + slen);
         if (c == done_c && !we) begin
            if (ch < 0 || timed_out) exp_dat = 32'hFFFF_FFFF;
            else                     exp_dat = {{(32-DW){1'b0}}, sd[ch*DW +: DW]};
         end
         chk({name, " stb"},  32'(bus.s_stb), in_strobe ? 32'(oh) : 32'h0);
         chk({name, " s_we"}, 32'(bus.s_we), 32'(in_strobe && we));
         chk({name, " ack"},  32'(bus.wb_ack), 32'(c == done_c && !timed_out));
         chk({name, " err"},  32'(bus.wb_err), 32'(c == done_c && timed_out));
         chk({name, " dat"},  bus.wb_dat_o, exp_dat);
         chk({name, " sdat"}, 32'(bus.s_dat_o), 32'(exp_sdat));
         // Latched fields must not follow later input changes; acks on other channels are noise.
         bus.sel_i   = NSLV'($urandom);
         bus.speed_i = 2'($urandom);
         bus.s_ack_i = NSLV'($urandom) & ~oh;
         if (in_strobe && (c - sstart) == dly) bus.s_ack_i = bus.s_ack_i | oh;
         if (kind == 1 && c == at) begin
            bus.wb_cyc = 1'b0;
            bus.wb_stb = 1'b0;
         end
         tick();
      end
      // First IDLE cycle after DONE; the request held through DONE was not taken.
      chk_idle({name, " idle"});
   endtask

   initial begin
      logic [NSLV*DW-1:0] sd;
      logic [NSLV-1:0] rsel;
      int rdly, rkind;

      bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0; bus.wb_dat_i = '0;
      bus.sel_i = '0; bus.speed_i = '0; bus.s_ack_i = '0; bus.s_dat_i = '0;

      #12;
      chk_idle("reset");
      chk("reset sdat", 32'(bus.s_dat_o), 32'h0);

      @(negedge clkcpu) rst_n = 1'b1;

      sd = rand_sd();
      sd[1*DW +: DW] = 16'h00A5;
      run_txn("rd_sync", 8'h02, 2'd3, 1'b0, $urandom, 0, sd, 0, 0);
      chk("rd_sync value", bus.wb_dat_o, 32'h0000_00A5);

      run_txn("wr_slow", 8'h10, 2'd0, 1'b1, 32'h1234_0000, 2, rand_sd(), 0, 0);
      chk("wr_slow keeps rdata", bus.wb_dat_o, 32'h0000_00A5);

      run_txn("none_fast", 8'h00, 2'd2, 1'b0, $urandom, 0, rand_sd(), 0, 0);
      chk("none value", bus.wb_dat_o, 32'hFFFF_FFFF);

      run_txn("rd_ok", 8'h80, 2'd1, 1'b0, $urandom, 3, rand_sd(), 0, 0);
      run_txn("timeout", 8'h0C, 2'd1, 1'b0, $urandom, TIMEOUT, rand_sd(), 0, 0);
      chk("timeout value", bus.wb_dat_o, 32'hFFFF_FFFF);

      for (int t = 0; t < 40; t++) begin
         rsel  = ($urandom % 8 == 0) ? '0 : NSLV'($urandom);
         rdly  = ($urandom % 10 == 0) ? TIMEOUT : int'($urandom % 7);
         rkind = ($urandom % 5 == 0) ? 1 : 0;
         run_txn($sformatf("rnd%0d", t), rsel, 2'($urandom), 1'($urandom), $urandom,
                 rdly, rand_sd(), rkind, 0);
      end

      run_txn("drop_wait", 8'h04, 2'd0, 1'b0, $urandom, 5, rand_sd(), 1, 2);
      run_txn("rst_strobe", 8'h20, 2'd1, 1'b1, $urandom, 10, rand_sd(), 2, 10);
      run_txn("after_rst", 8'h01, 2'd3, 1'b0, $urandom, 1, rand_sd(), 0, 0);

      bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.s_ack_i = '0;
      tick();
      chk_idle("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
